// File: rtl/axi_addr_ch_rx.sv
// rtl/axi_addr_ch_rx.sv - RAB address channel receive stage: captures one AXI address beat,
// translates it through a segment table and hands a hit to tx or raises a fault record.
module axi_addr_ch_rx #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int USER_WIDTH = 2,
  parameter int NUM_SEG    = 4,
  localparam int IDX_W     = $clog2(NUM_SEG)
) (
  input  logic                  rx_clk,
  input  logic                  reset,
  input  logic [ID_WIDTH-1:0]   s_id,
  input  logic [ADDR_WIDTH-1:0] s_addr,
  input  logic [7:0]            s_len,
  input  logic [2:0]            s_size,
  input  logic [1:0]            s_burst,
  input  logic [2:0]            s_prot,
  input  logic [3:0]            s_cache,
  input  logic [USER_WIDTH-1:0] s_user,
  input  logic                  s_lock,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ID_WIDTH-1:0]   out_id,
  output logic [7:0]            out_len,
  output logic [2:0]            out_size,
  output logic [1:0]            out_burst,
  output logic [2:0]            out_prot,
  output logic [3:0]            out_cache,
  output logic [USER_WIDTH-1:0] out_user,
  output logic                  out_lock,
  output logic [ADDR_WIDTH-1:0] phy_addr,
  output logic                  t_done,
  input  logic                  tx_busy,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [ADDR_WIDTH-1:0] cfg_vbase,
  input  logic [ADDR_WIDTH-1:0] cfg_vlimit,
  input  logic [ADDR_WIDTH-1:0] cfg_pbase,
  input  logic                  cfg_en,
  output logic                  fault_valid,
  output logic [ID_WIDTH-1:0]   fault_id,
  output logic [ADDR_WIDTH-1:0] fault_addr,
  input  logic                  fault_ack
);

  localparam int WW = ADDR_WIDTH + 16;

  typedef enum logic [1:0] {IDLE, LOOKUP, XLATED, FAULT} state_t;
  state_t state_q, state_d;

  logic                  s_ready_q, t_done_q, fault_valid_q;
  logic [ID_WIDTH-1:0]   id_q, fault_id_q;
  logic [ADDR_WIDTH-1:0] addr_q, phy_q, fault_addr_q;
  logic [7:0]            len_q;
  logic [2:0]            size_q, prot_q;
  logic [1:0]            burst_q;
  logic [3:0]            cache_q;
  logic [USER_WIDTH-1:0] user_q;
  logic                  lock_q;

  logic [ADDR_WIDTH-1:0] vbase_q  [NUM_SEG];
  logic [ADDR_WIDTH-1:0] vlimit_q [NUM_SEG];
  logic [ADDR_WIDTH-1:0] pbase_q  [NUM_SEG];
  logic [NUM_SEG-1:0]    en_q;

  logic                  accept;
  logic [WW-1:0]         beat_bytes, span_end;
  logic                  hit;
  logic [ADDR_WIDTH-1:0] hit_phy;

  assign accept = s_valid & s_ready_q & (state_q == IDLE);

  // Span end is kept 16 bits wider so a burst carrying past the top of the address space never hits.
  always_comb begin
    beat_bytes = (WW'(len_q) + WW'(1)) << size_q;
    span_end   = WW'(addr_q) + beat_bytes - WW'(1);
    hit        = 1'b0;
    hit_phy    = '0;
    for (int i = NUM_SEG - 1; i >= 0; i--) begin
      if (en_q[i] && (addr_q >= vbase_q[i]) && (span_end <= WW'(vlimit_q[i]))) begin
        hit     = 1'b1;
        hit_phy = addr_q - vbase_q[i] + pbase_q[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = LOOKUP;
      LOOKUP:  state_d = hit ? XLATED : FAULT;
      XLATED:  if (!tx_busy) state_d = IDLE;
      FAULT:   if (fault_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rx_clk) begin
    if (reset) begin
      state_q       <= IDLE;
      s_ready_q     <= 1'b0;
      t_done_q      <= 1'b0;
      fault_valid_q <= 1'b0;
      fault_id_q    <= '0;
      fault_addr_q  <= '0;
      phy_q         <= '0;
      id_q          <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      size_q        <= '0;
      burst_q       <= '0;
      prot_q        <= '0;
      cache_q       <= '0;
      user_q        <= '0;
      lock_q        <= 1'b0;
      en_q          <= '0;
    end else begin
      state_q   <= state_d;
      // Registered ready keeps the consumption cycle from also accepting a new beat.
      s_ready_q <= (state_d == IDLE);
      if (accept) begin
        id_q    <= s_id;
        addr_q  <= s_addr;
        len_q   <= s_len;
        size_q  <= s_size;
        burst_q <= s_burst;
        prot_q  <= s_prot;
        cache_q <= s_cache;
        user_q  <= s_user;
        lock_q  <= s_lock;
      end
      if (state_q == LOOKUP) begin
        if (hit) begin
          phy_q    <= hit_phy;
          t_done_q <= 1'b1;
        end else begin
          fault_valid_q <= 1'b1;
          fault_id_q    <= id_q;
          fault_addr_q  <= addr_q;
        end
      end
      if ((state_q == XLATED) && !tx_busy) t_done_q <= 1'b0;
      if ((state_q == FAULT) && fault_ack) fault_valid_q <= 1'b0;
      if (cfg_we) en_q[cfg_idx] <= cfg_en;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (cfg_we) begin
      vbase_q[cfg_idx]  <= cfg_vbase;
      vlimit_q[cfg_idx] <= cfg_vlimit;
      pbase_q[cfg_idx]  <= cfg_pbase;
    end
  end

  assign s_ready     = s_ready_q;
  assign t_done      = t_done_q;
  assign phy_addr    = phy_q;
  assign out_id      = id_q;
  assign out_len     = len_q;
  assign out_size    = size_q;
  assign out_burst   = burst_q;
  assign out_prot    = prot_q;
  assign out_cache   = cache_q;
  assign out_user    = user_q;
  assign out_lock    = lock_q;
  assign fault_valid = fault_valid_q;
  assign fault_id    = fault_id_q;
  assign fault_addr  = fault_addr_q;

endmodule
